// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream with burst framing.
// A two-entry skid buffer covers the one-cycle FIFO read latency and downstream stalls.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  words_sent_o
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

    logic       pop;
    logic [2:0] level;
    logic       rd_en;

    assign m_valid_o    = (occ_q != 2'd0);
    assign m_data_o     = buf0_q;
    assign m_last_o     = m_valid_o && (beat_q == BEAT_LAST);
    assign busy_o       = (state_q != IDLE);
    assign words_sent_o = words_q;
    assign fifo_rd_en_o = rd_en;

    assign pop = m_valid_o && m_ready_i;

    // Occupancy as it will stand after this cycle's pop, including the word in flight.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en = (state_q == RUN) && !fifo_empty_i && (level < 3'd2);

    // buf0 is always the head; buf1 only holds a word when occ is 2.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data_i;
                end else begin
                    buf1_d = fifo_data_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_i;
                end else begin
                    buf0_d = fifo_data_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        beat_d  = beat_q;
        words_d = words_q;
        if (pop) begin
            beat_d  = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
            words_d = words_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = RUN;
            end
            RUN: begin
                if (!enable_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable_i) begin
                    state_d = RUN;
                end else if (occ_q == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            words_q    <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            beat_q     <= beat_d;
            words_q    <= words_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: vector table for streaming plus hand sequences
// for backpressure, empty, drain, reset and burst continuity.
module tb_fifo_stream_reader;

    localparam int DW = 64;
    localparam int BL = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          m_ready = 1'b1;
    logic          fifo_rd_en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [CW-1:0] words_sent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .fifo_rd_en_o(fifo_rd_en),
        .fifo_data_i (fifo_data),
        .fifo_empty_i(fifo_empty),
        .m_valid_o   (m_valid),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .m_ready_i   (m_ready),
        .busy_o      (busy),
        .words_sent_o(words_sent)
    );

    // FIFO model with one-cycle registered read latency.
    logic [DW-1:0] mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          flush = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Monitor: collects transfers and checks stall stability and read-issue rules.
    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } xfer_t;

    xfer_t         rx_q[$];
    int            out_cnt = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          stall_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            out_cnt <= 0;
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 64'(m_valid), 64'(1));
                check("hold_data", m_data, stall_data);
                check("hold_last", 64'(m_last), 64'(stall_last));
            end
            if (fifo_rd_en) begin
                check("rd_while_empty", 64'(fifo_empty), 64'(0));
                check("rd_when_full", 64'(out_cnt - int'(m_valid && m_ready) >= 2), 64'(0));
            end
            if (m_valid && m_ready) rx_q.push_back('{last: m_last, data: m_data});
            stall_q    <= m_valid && !m_ready;
            stall_data <= m_data;
            stall_last <= m_last;
            out_cnt    <= out_cnt + int'(fifo_rd_en) - int'(m_valid && m_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && busy; i++) step();
        check(name, 64'(busy), 64'(0));
    endtask

    task automatic wait_rx(input string name, input int n);
        for (int i = 0; i < 60 && rx_q.size() < n; i++) step();
        check(name, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          rd;
        logic          vld;
        logic [DW-1:0] data;
        logic          last;
        logic          bsy;
        int            cnt;
    } vec_t;

    vec_t vecs[14];
    int   rd_cnt;

    initial begin
        // Streaming: 8 preloaded words, BURST_LEN=4, ready held high.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h1, 1'b0, 1'b1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h2, 1'b0, 1'b1, 1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h3, 1'b0, 1'b1, 2};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h4, 1'b1, 1'b1, 3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h5, 1'b0, 1'b1, 4};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h6, 1'b0, 1'b1, 5};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h7, 1'b0, 1'b1, 6};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h8, 1'b1, 1'b1, 7};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 8};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 8};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 8};

        // Reset state
        @(negedge clk);
        check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_data", m_data, 64'h0);
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_words", 64'(words_sent), 64'(0));
        step();
        step();
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) push(64'(i));
        for (int i = 0; i < 14; i++) begin
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_rd_en", i), 64'(fifo_rd_en), 64'(vecs[i].rd));
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vecs[i].vld));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
            check($sformatf("vec%0d_words", i), 64'(words_sent), 64'(vecs[i].cnt));
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_data", i), m_data, vecs[i].data);
                check($sformatf("vec%0d_last", i), 64'(m_last), 64'(vecs[i].last));
            end else begin
                check($sformatf("vec%0d_last_idle", i), 64'(m_last), 64'(0));
            end
            step();
        end

        // Backpressure: ready pattern 1,0,0,1 repeating
        rx_q.delete();
        for (int i = 0; i < 8; i++) push(64'(32'h11 + i));
        enable = 1'b1;
        for (int i = 0; i < 200 && rx_q.size() < 8; i++) begin
            m_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        check("bp_count", 64'(rx_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            check($sformatf("bp_data%0d", i), rx_q[i].data, 64'(32'h11 + i));
            check($sformatf("bp_last%0d", i), 64'(rx_q[i].last), 64'(i == 3 || i == 7));
        end
        enable  = 1'b0;
        m_ready = 1'b1;
        wait_idle("bp_idle");

        // Empty: a single word, then the FIFO stays empty
        rx_q.delete();
        push(64'h21);
        enable = 1'b1;
        rd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            step();
        end
        check("empty_rd_count", 64'(rd_cnt), 64'(1));
        check("empty_rx_count", 64'(rx_q.size()), 64'(1));
        if (rx_q.size() > 0) check("empty_rx_data", rx_q[0].data, 64'h21);
        enable = 1'b0;
        wait_idle("empty_idle");

        // Drain: drop enable with one word buffered and one in flight
        rx_q.delete();
        m_ready = 1'b0;
        push(64'h31);
        push(64'h32);
        push(64'h33);
        enable = 1'b1;
        step();
        @(negedge clk);
        check("drain_c1_rd", 64'(fifo_rd_en), 64'(1));
        step();
        @(negedge clk);
        check("drain_c2_rd", 64'(fifo_rd_en), 64'(1));
        step();
        enable = 1'b0;
        @(negedge clk);
        check("drain_c3_rd", 64'(fifo_rd_en), 64'(0));
        check("drain_c3_valid", 64'(m_valid), 64'(1));
        check("drain_c3_data", m_data, 64'h31);
        step();
        m_ready = 1'b1;
        @(negedge clk);
        check("drain_c4_rd", 64'(fifo_rd_en), 64'(0));
        check("drain_c4_data", m_data, 64'h31);
        check("drain_c4_busy", 64'(busy), 64'(1));
        step();
        @(negedge clk);
        check("drain_c5_rd", 64'(fifo_rd_en), 64'(0));
        check("drain_c5_valid", 64'(m_valid), 64'(1));
        check("drain_c5_data", m_data, 64'h32);
        check("drain_c5_busy", 64'(busy), 64'(1));
        step();
        @(negedge clk);
        check("drain_c6_valid", 64'(m_valid), 64'(0));
        check("drain_c6_busy", 64'(busy), 64'(1));
        step();
        @(negedge clk);
        check("drain_c7_busy", 64'(busy), 64'(0));
        check("drain_c7_rd", 64'(fifo_rd_en), 64'(0));
        check("drain_rx_count", 64'(rx_q.size()), 64'(2));
        step();
        do_flush();

        // Reset mid-stream with the buffer full
        rx_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(64'(32'h41 + i));
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("rstm_pre_data", m_data, 64'h41);
        rst_n = 1'b0;
        #1;
        check("rstm_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rstm_valid", 64'(m_valid), 64'(0));
        check("rstm_data", m_data, 64'h0);
        check("rstm_last", 64'(m_last), 64'(0));
        check("rstm_busy", 64'(busy), 64'(0));
        check("rstm_words", 64'(words_sent), 64'(0));
        enable = 1'b0;
        do_flush();
        step();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstm_post_valid%0d", i), 64'(m_valid), 64'(0));
            step();
        end

        // Burst continuity across an enable gap
        rx_q.delete();
        push(64'h51);
        push(64'h52);
        push(64'h53);
        enable = 1'b1;
        wait_rx("burst_rx3", 3);
        enable = 1'b0;
        wait_idle("burst_idle1");
        push(64'h54);
        enable = 1'b1;
        wait_rx("burst_rx4", 4);
        enable = 1'b0;
        wait_idle("burst_idle2");
        if (rx_q.size() >= 4) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("burst_last%0d", i), 64'(rx_q[i].last), 64'(0));
            end
            check("burst_data3", rx_q[3].data, 64'h54);
            check("burst_last3", 64'(rx_q[3].last), 64'(1));
        end
        check("burst_words", 64'(words_sent), 64'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous circular FIFO. It pops words through the FIFO's read port (`rd_en`, `data`, `empty`, one-cycle registered read latency) and presents them on a valid/ready stream with burst framing (`m_last_o`). A two-entry output buffer absorbs the FIFO read latency and downstream backpressure, so throughput is one word per cycle with no word lost or duplicated.

## Interface
- `DATA_WIDTH`, 64, word width; matches the FIFO.
- `BURST_LEN`, 16, words per burst; `m_last_o` marks the final word of each burst; must be ≥1.
- `CNT_WIDTH`, 32, width of the `words_sent_o` counter.
- `clk_i` in 1 — the single clock.
- `rst_n_i` in 1 — asynchronous, active-low reset.
- `enable_i` in 1 — level; high permits draining.
- `fifo_rd_en_o` out 1 — FIFO pop request.
- `fifo_data_i` in DATA_WIDTH — FIFO read data, valid the cycle after `fifo_rd_en_o`.
- `fifo_empty_i` in 1 — FIFO empty flag.
- `m_valid_o` out 1 — output word valid.
- `m_data_o` out DATA_WIDTH — output word.
- `m_last_o` out 1 — last word of the burst.
- `m_ready_i` in 1 — downstream accept.
- `busy_o` out 1 — high in RUN or DRAIN.
- `words_sent_o` out CNT_WIDTH — total accepted words; wraps modulo 2^CNT_WIDTH.

## Operation
- Handshake: a word transfers in a cycle where `m_valid_o && m_ready_i`. Once `m_valid_o` is asserted, it and `m_data_o`/`m_last_o` hold stable until the transfer.
- Buffer: 2-entry FIFO-ordered skid. `occ` counts entries (0..2); `inflight` is 1 in the cycle after a pop is issued; `pop` = `m_valid_o && m_ready_i`.
- Read issue (combinational): `fifo_rd_en_o = (state==RUN) && !fifo_empty_i && (occ + inflight - pop) < 2`. The FIFO is never popped while empty, and the buffer never overflows.
- Capture: when `inflight`, `fifo_data_i` is written into the buffer at the next edge.
- Beat counter: runs 0..BURST_LEN-1 and wraps to 0. `m_last_o` = (beat == BURST_LEN-1) for the head word. The counter advances only on a transfer. `BURST_LEN=1` gives `m_last_o` on every word.
- `words_sent_o` increments by 1 on each transfer.
- FSM:
  - IDLE → RUN when `enable_i`=1.
  - RUN → DRAIN when `enable_i`=0.
  - DRAIN: no new reads. Outstanding and buffered words are still delivered.
  - DRAIN → IDLE when `occ==0 && !inflight`.
  - DRAIN → RUN if `enable_i` rises again.
- The beat counter is not reset by DRAIN or IDLE; burst framing continues across enable gaps. It is cleared only by reset.

## Timing
- Reset (asynchronous assert, takes effect immediately) sets:
  - state = IDLE;
  - `fifo_rd_en_o`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `busy_o`=0, `words_sent_o`=0;
  - `occ`=0, `inflight`=0, beat=0.
- Reset mid-operation discards buffered and in-flight words. A FIFO word popped in the cycle before reset is lost; this is acceptable by design.
- Enable latency: `enable_i` rises at edge E, state is RUN after E, and `fifo_rd_en_o` may assert in cycle E+1.
- Data latency: `fifo_rd_en_o` in cycle N, data on `fifo_data_i` in cycle N+1, `m_valid_o` high in cycle N+2.
- With `m_ready_i`=1 and the FIFO non-empty, the block sustains one transfer per cycle.
- `m_ready_i`=0 for k cycles:
  - reads stop once `occ + inflight` = 2;
  - after `m_ready_i` returns, transfers resume that same cycle, back-to-back, with no bubble.
- Simultaneous capture and pop: `occ` is unchanged, and data order is preserved.
- `fifo_empty_i` rises: reads stop the same cycle; buffered words are still delivered.

## Test plan
- Reset: assert `rst_n_i`=0 mid-stream with `occ`=2 → all outputs 0 immediately; after release, `m_valid_o` stays 0 until `enable_i`.
- Streaming: preload 8 words 0x1..0x8, `BURST_LEN`=4, `m_ready_i`=1, raise `enable_i` →
  - first `m_valid_o` 2 cycles after the first `fifo_rd_en_o`;
  - 8 consecutive transfers;
  - `m_last_o` on 0x4 and 0x8;
  - `words_sent_o`=8.
- Backpressure: 8 words, `m_ready_i` toggled 1,0,0,1,… →
  - output sequence exactly 0x1..0x8, no duplicates;
  - `fifo_rd_en_o` never asserted while `occ + inflight` = 2;
  - data held stable while stalled.
- Empty: FIFO holds 1 word, then stays empty → exactly one `fifo_rd_en_o`; `fifo_rd_en_o` is never high while `fifo_empty_i`=1.
- Drain: drop `enable_i` with `inflight`=1 and `occ`=1 →
  - no further `fifo_rd_en_o`;
  - both words delivered;
  - `busy_o` falls the cycle after `occ` reaches 0.
- Burst continuity: `BURST_LEN`=4, send 3 words, disable until IDLE, re-enable, send 1 word → that word carries `m_last_o`=1.
